// File: rtl/ctrl_pkg.sv
// Shared encodings for the fetch/decode/execute sequencer: states, opcodes,
// ALU selects and the decoded-instruction payload.
package ctrl_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned SELW = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_DEC  = 3'd4,
    S_MEM  = 3'd5,
    S_EX   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LDA = 4'h1;
  localparam logic [OPW-1:0] OP_STA = 4'h2;
  localparam logic [OPW-1:0] OP_ADD = 4'h3;
  localparam logic [OPW-1:0] OP_SUB = 4'h4;
  localparam logic [OPW-1:0] OP_AND = 4'h5;
  localparam logic [OPW-1:0] OP_OR  = 4'h6;
  localparam logic [OPW-1:0] OP_XOR = 4'h7;
  localparam logic [OPW-1:0] OP_NOT = 4'h8;
  localparam logic [OPW-1:0] OP_JMP = 4'h9;
  localparam logic [OPW-1:0] OP_JZ  = 4'hA;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  localparam logic [SELW-1:0] SEL_ADD    = 3'b000;
  localparam logic [SELW-1:0] SEL_SUB    = 3'b001;
  localparam logic [SELW-1:0] SEL_AND    = 3'b010;
  localparam logic [SELW-1:0] SEL_OR     = 3'b011;
  localparam logic [SELW-1:0] SEL_XOR    = 3'b100;
  localparam logic [SELW-1:0] SEL_NOT    = 3'b101;
  localparam logic [SELW-1:0] SEL_PASS_B = 3'b110;
  localparam logic [SELW-1:0] SEL_PASS_A = 3'b111;

  typedef struct packed {
    logic            needs_mem;
    logic            is_store;
    logic            is_jump;
    logic            is_cond;
    logic            is_halt;
    logic            is_unary;
    logic [SELW-1:0] alu_sel;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier; undefined opcodes decode to all-zero (NOP).
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output dec_t           dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_LDA: begin dec.needs_mem = 1'b1; dec.alu_sel = SEL_PASS_B; end
      OP_STA: begin dec.needs_mem = 1'b1; dec.is_store = 1'b1; end
      OP_ADD: begin dec.needs_mem = 1'b1; dec.alu_sel = SEL_ADD; end
      OP_SUB: begin dec.needs_mem = 1'b1; dec.alu_sel = SEL_SUB; end
      OP_AND: begin dec.needs_mem = 1'b1; dec.alu_sel = SEL_AND; end
      OP_OR:  begin dec.needs_mem = 1'b1; dec.alu_sel = SEL_OR;  end
      OP_XOR: begin dec.needs_mem = 1'b1; dec.alu_sel = SEL_XOR; end
      OP_NOT: begin dec.is_unary  = 1'b1; dec.alu_sel = SEL_NOT; end
      OP_JMP: dec.is_jump = 1'b1;
      OP_JZ:  begin dec.is_jump = 1'b1; dec.is_cond = 1'b1; end
      OP_HLT: dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: registered state, memory wait
// counter with timeout, and combinational control decode.
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  input  logic            zero,
  output logic            pc_inc,
  output logic            pc_ld,
  output logic            mar_ld,
  output logic            ir_ld,
  output logic            mdr_ld,
  output logic            acc_ld,
  output logic            mem_wr,
  output logic            pc_en,
  output logic            mar_en,
  output logic            pm_en,
  output logic            alu_en,
  output logic            ir_en,
  output logic            mdr_en,
  output logic [SELW-1:0] alu_sel,
  output logic            halted,
  output logic            bus_err
);

  localparam int unsigned WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  state_t         state, state_n, nxt;
  logic [WCW-1:0] wait_cnt;
  logic           wait_max;
  logic           timeout;
  dec_t           dec;

  instr_decoder u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  assign wait_max = (wait_cnt == WCW'(WAIT_MAX));

  // State register, wait counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      halted   <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_n;
      // Any state change clears the counter, so S_F1/S_MEM always start at 0.
      if (state_n != state) begin
        wait_cnt <= '0;
      end else if (!mem_ready && (state == S_F1 || state == S_MEM)) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end
      halted <= (state_n == S_HALT);
      if (timeout) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_n = state;
    timeout = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    mar_ld  = 1'b0;
    ir_ld   = 1'b0;
    mdr_ld  = 1'b0;
    acc_ld  = 1'b0;
    mem_wr  = 1'b0;
    pc_en   = 1'b0;
    mar_en  = 1'b0;
    pm_en   = 1'b0;
    alu_en  = 1'b0;
    ir_en   = 1'b0;
    mdr_en  = 1'b0;
    alu_sel = '0;
    nxt     = run ? S_F0 : S_IDLE;

    case (state)
      S_IDLE: if (run) state_n = S_F0;
      S_F0: begin
        pc_en   = 1'b1;
        mar_ld  = 1'b1;
        state_n = S_F1;
      end
      S_F1: begin
        mar_en = 1'b1;
        pm_en  = 1'b1;
        if (mem_ready) begin
          ir_ld   = 1'b1;
          state_n = S_F2;
        end else if (wait_max) begin
          timeout = 1'b1;
          state_n = S_HALT;
        end
      end
      S_F2: begin
        pc_inc  = 1'b1;
        state_n = S_DEC;
      end
      S_DEC: begin
        if (dec.needs_mem) begin
          ir_en   = 1'b1;
          mar_ld  = 1'b1;
          state_n = S_MEM;
        end else if (dec.is_unary) begin
          state_n = S_EX;
        end else if (dec.is_jump) begin
          if (!dec.is_cond || zero) begin
            ir_en = 1'b1;
            pc_ld = 1'b1;
          end
          state_n = nxt;
        end else if (dec.is_halt) begin
          state_n = S_HALT;
        end else begin
          state_n = nxt;
        end
      end
      S_MEM: begin
        mar_en = 1'b1;
        if (dec.is_store) begin
          alu_en = 1'b1;
          mem_wr = 1'b1;
        end else begin
          pm_en = 1'b1;
        end
        if (mem_ready) begin
          mdr_ld  = !dec.is_store;
          state_n = dec.is_store ? nxt : S_EX;
        end else if (wait_max) begin
          timeout = 1'b1;
          state_n = S_HALT;
        end
      end
      S_EX: begin
        acc_ld  = 1'b1;
        alu_sel = dec.alu_sel;
        mdr_en  = !dec.is_unary;
        state_n = nxt;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: per-instruction control traces from a vector table,
// plus hand sequences for stalls, timeout, run drop and halt.
module tb_instr_sequencer;

  logic       clk, rst, run, mem_ready, zero;
  logic [3:0] opcode;
  logic pc_inc, pc_ld, mar_ld, ir_ld, mdr_ld, acc_ld, mem_wr;
  logic pc_en, mar_en, pm_en, alu_en, ir_en, mdr_en;
  logic [2:0] alu_sel;
  logic halted, bus_err;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .mar_ld(mar_ld), .ir_ld(ir_ld), .mdr_ld(mdr_ld),
    .acc_ld(acc_ld), .mem_wr(mem_wr), .pc_en(pc_en), .mar_en(mar_en), .pm_en(pm_en),
    .alu_en(alu_en), .ir_en(ir_en), .mdr_en(mdr_en), .alu_sel(alu_sel),
    .halted(halted), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {pc_inc,pc_ld,mar_ld,ir_ld,mdr_ld,acc_ld,mem_wr,pc_en,mar_en,pm_en,alu_en,ir_en,mdr_en,alu_sel}
  localparam logic [15:0] W_IDLE = 16'h0000;
  localparam logic [15:0] W_F0   = 16'h2100;
  localparam logic [15:0] W_F1   = 16'h10C0;
  localparam logic [15:0] W_F1W  = 16'h00C0;
  localparam logic [15:0] W_F2   = 16'h8000;
  localparam logic [15:0] W_DM   = 16'h2010;
  localparam logic [15:0] W_DJ   = 16'h4010;
  localparam logic [15:0] W_MR   = 16'h08C0;
  localparam logic [15:0] W_MW   = 16'h02A0;
  localparam logic [15:0] W_EXB  = 16'h0408;

  typedef struct packed {
    logic [15:0] ctrl;
    logic        halted;
    logic        bus_err;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic        zero;
    logic [15:0] w_dec;
    logic        has_mem;
    logic [15:0] w_mem;
    logic        has_ex;
    logic [15:0] w_ex;
  } vec_t;

  exp_t  sbq[$];
  vec_t  vec[14];
  int    checks = 0;
  int    failures = 0;
  int    cyc_no = 0;
  string tag = "reset";

  function automatic vec_t mkv(input logic [3:0] op, input logic z, input logic [15:0] wd,
                               input logic hm, input logic [15:0] wm,
                               input logic he, input logic [15:0] we);
    vec_t v;
    v.op = op; v.zero = z; v.w_dec = wd;
    v.has_mem = hm; v.w_mem = wm; v.has_ex = he; v.w_ex = we;
    return v;
  endfunction

  task automatic push(input logic [15:0] c, input logic h, input logic b);
    exp_t e;
    e.ctrl = c; e.halted = h; e.bus_err = b;
    sbq.push_back(e);
  endtask

  // One clock: drive mem_ready, check outputs mid-cycle against the scoreboard head.
  task automatic cyc(input logic mr);
    exp_t e;
    logic [15:0] act;
    logic inv_ok;
    mem_ready = mr;
    @(negedge clk);
    cyc_no++;
    act = {pc_inc, pc_ld, mar_ld, ir_ld, mdr_ld, acc_ld, mem_wr,
           pc_en, mar_en, pm_en, alu_en, ir_en, mdr_en, alu_sel};
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s cyc=%0d scoreboard empty, got ctrl=%h", tag, cyc_no, act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.ctrl || halted !== e.halted || bus_err !== e.bus_err) begin
        failures++;
        $display("FAIL %s cyc=%0d ctrl=%h halted=%b bus_err=%b expected ctrl=%h halted=%b bus_err=%b",
                 tag, cyc_no, act, halted, bus_err, e.ctrl, e.halted, e.bus_err);
      end
    end
    inv_ok = !(pc_en && mar_en) && ($countones({pm_en, alu_en, ir_en}) <= 1) &&
             (!mem_wr || alu_en) && (acc_ld || alu_sel == 3'b000);
    checks++;
    if (!inv_ok) begin
      failures++;
      $display("FAIL %s_invariant cyc=%0d ctrl=%h expected no bus/strobe conflict", tag, cyc_no, act);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    vec[0]  = mkv(4'h0, 1'b0, W_IDLE, 1'b0, '0,   1'b0, '0);
    vec[1]  = mkv(4'h1, 1'b0, W_DM,   1'b1, W_MR, 1'b1, W_EXB | 16'h0006);
    vec[2]  = mkv(4'h2, 1'b0, W_DM,   1'b1, W_MW, 1'b0, '0);
    vec[3]  = mkv(4'h3, 1'b0, W_DM,   1'b1, W_MR, 1'b1, W_EXB | 16'h0000);
    vec[4]  = mkv(4'h4, 1'b0, W_DM,   1'b1, W_MR, 1'b1, W_EXB | 16'h0001);
    vec[5]  = mkv(4'h5, 1'b1, W_DM,   1'b1, W_MR, 1'b1, W_EXB | 16'h0002);
    vec[6]  = mkv(4'h6, 1'b0, W_DM,   1'b1, W_MR, 1'b1, W_EXB | 16'h0003);
    vec[7]  = mkv(4'h7, 1'b0, W_DM,   1'b1, W_MR, 1'b1, W_EXB | 16'h0004);
    vec[8]  = mkv(4'h8, 1'b0, W_IDLE, 1'b0, '0,   1'b1, 16'h0405);
    vec[9]  = mkv(4'h9, 1'b0, W_DJ,   1'b0, '0,   1'b0, '0);
    vec[10] = mkv(4'hA, 1'b1, W_DJ,   1'b0, '0,   1'b0, '0);
    vec[11] = mkv(4'hA, 1'b0, W_IDLE, 1'b0, '0,   1'b0, '0);
    vec[12] = mkv(4'hB, 1'b1, W_IDLE, 1'b0, '0,   1'b0, '0);
    vec[13] = mkv(4'hE, 1'b0, W_IDLE, 1'b0, '0,   1'b0, '0);

    rst = 1'b1; run = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b1;
    push(W_IDLE, 1'b0, 1'b0); push(W_IDLE, 1'b0, 1'b0);
    cyc(1'b1); cyc(1'b1);
    rst = 1'b0; run = 1'b1;
    tag = "idle";
    push(W_IDLE, 1'b0, 1'b0); cyc(1'b1);

    // Back-to-back instructions with zero-wait memory; each begins in S_F0.
    for (int i = 0; i < 14; i++) begin
      int n;
      tag = $sformatf("vec%0d_op%h", i, vec[i].op);
      opcode = vec[i].op; zero = vec[i].zero;
      push(W_F0, 1'b0, 1'b0); push(W_F1, 1'b0, 1'b0);
      push(W_F2, 1'b0, 1'b0); push(vec[i].w_dec, 1'b0, 1'b0);
      if (vec[i].has_mem) push(vec[i].w_mem, 1'b0, 1'b0);
      if (vec[i].has_ex)  push(vec[i].w_ex, 1'b0, 1'b0);
      n = 4 + int'(vec[i].has_mem) + int'(vec[i].has_ex);
      repeat (n) cyc(1'b1);
    end

    // mem_ready arriving on the final allowed wait cycle is still a success.
    tag = "f1_wait_edge"; opcode = 4'h0;
    push(W_F0, 1'b0, 1'b0); cyc(1'b1);
    repeat (15) begin push(W_F1W, 1'b0, 1'b0); cyc(1'b0); end
    push(W_F1, 1'b0, 1'b0); cyc(1'b1);
    push(W_F2, 1'b0, 1'b0); cyc(1'b1);
    push(W_IDLE, 1'b0, 1'b0); cyc(1'b1);

    // STA with a three-cycle write stall.
    tag = "sta_stall"; opcode = 4'h2;
    push(W_F0, 1'b0, 1'b0); push(W_F1, 1'b0, 1'b0);
    push(W_F2, 1'b0, 1'b0); push(W_DM, 1'b0, 1'b0);
    repeat (4) cyc(1'b1);
    repeat (4) push(W_MW, 1'b0, 1'b0);
    repeat (3) cyc(1'b0);
    cyc(1'b1);

    // LDA with run dropped during S_EX.
    tag = "lda_run_drop"; opcode = 4'h1;
    push(W_F0, 1'b0, 1'b0); push(W_F1, 1'b0, 1'b0); push(W_F2, 1'b0, 1'b0);
    push(W_DM, 1'b0, 1'b0); push(W_MR, 1'b0, 1'b0);
    repeat (5) cyc(1'b1);
    run = 1'b0;
    push(W_EXB | 16'h0006, 1'b0, 1'b0); cyc(1'b1);
    push(W_IDLE, 1'b0, 1'b0); cyc(1'b1);
    push(W_IDLE, 1'b0, 1'b0); cyc(1'b1);
    run = 1'b1;
    push(W_IDLE, 1'b0, 1'b0); cyc(1'b1);

    // HLT holds regardless of run; only rst leaves.
    tag = "hlt"; opcode = 4'hF;
    push(W_F0, 1'b0, 1'b0); push(W_F1, 1'b0, 1'b0);
    push(W_F2, 1'b0, 1'b0); push(W_IDLE, 1'b0, 1'b0);
    repeat (4) cyc(1'b1);
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      push(W_IDLE, 1'b1, 1'b0); cyc(k[1]);
    end
    rst = 1'b1;
    push(W_IDLE, 1'b1, 1'b0); cyc(1'b1);
    rst = 1'b0; run = 1'b1;
    push(W_IDLE, 1'b0, 1'b0); cyc(1'b1);

    // Fetch stall past WAIT_MAX: halt with sticky bus error.
    tag = "f1_timeout"; opcode = 4'h0;
    push(W_F0, 1'b0, 1'b0); cyc(1'b1);
    repeat (16) begin push(W_F1W, 1'b0, 1'b0); cyc(1'b0); end
    for (int k = 0; k < 4; k++) begin
      run = k[0];
      push(W_IDLE, 1'b1, 1'b1); cyc(1'b1);
    end
    rst = 1'b1;
    push(W_IDLE, 1'b1, 1'b1); cyc(1'b1);
    rst = 1'b0; run = 1'b1;
    push(W_IDLE, 1'b0, 1'b0); cyc(1'b1);
    tag = "restart";
    push(W_F0, 1'b0, 1'b0); cyc(1'b1);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
